// File: rtl/apb_uart_tx.sv
// APB-controlled UART transmitter: a one-entry holding buffer feeds a start/data/stop
// framer that shifts LSB first, using a bit period and data size captured at each frame start.
module apb_uart_tx #(
    parameter logic [13:0] RESET_BIT_PERIOD = 14'd10,
    parameter logic [3:0]  RESET_DATA_SIZE  = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic [2:0] paddr,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pslverr,
    output logic       serial_out
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state_q, state_d;
    logic [13:0] bit_period_q, bit_period_d;
    logic [3:0]  data_size_q, data_size_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  shift_q, shift_d;
    logic [13:0] cnt_q, cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [13:0] frame_period_q, frame_period_d;
    logic [3:0]  frame_size_q, frame_size_d;
    logic        serial_q, serial_d;

    logic access;
    logic size_ok;
    logic bit_done;
    logic load_frame;

    assign access     = psel & penable;
    assign size_ok    = (pwdata >= 8'd5) && (pwdata <= 8'd8);
    assign bit_done   = (cnt_q == frame_period_q);
    // The buffer empties on the edge a frame is loaded, so a write on that edge is not an overrun.
    assign load_frame = buf_full_q && ((state_q == S_IDLE) || (state_q == S_STOP && bit_done));
    assign serial_out = serial_q;

    always_comb begin
        pslverr = 1'b0;
        if (psel) begin
            case (paddr)
                3'd0, 3'd1: pslverr = pwrite;
                3'd4:       pslverr = pwrite & ~size_ok;
                3'd5, 3'd7: pslverr = 1'b1;
                default:    pslverr = 1'b0;
            endcase
        end
    end

    always_comb begin
        prdata = 8'h00;
        if (psel) begin
            case (paddr)
                3'd0:    prdata = {6'b0, buf_full_q, state_q != S_IDLE};
                3'd1:    prdata = {7'b0, overrun_q};
                3'd2:    prdata = bit_period_q[7:0];
                3'd3:    prdata = {2'b0, bit_period_q[13:8]};
                3'd4:    prdata = {4'b0, data_size_q};
                3'd6:    prdata = tx_data_q;
                default: prdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        // NOTE: every target gets its hold value first so no path through this block infers a latch.
        state_d        = state_q;
        bit_period_d   = bit_period_q;
        data_size_d    = data_size_q;
        tx_data_d      = tx_data_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        overrun_d      = overrun_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        frame_period_d = frame_period_q;
        frame_size_d   = frame_size_q;
        serial_d       = serial_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? 14'd1 : cnt_q + 14'd1;
        end

        case (state_q)
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    serial_d  = shift_q[0];
                    bit_idx_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == frame_size_q - 4'd1) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done && !buf_full_q) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (load_frame) begin
            state_d        = S_START;
            shift_d        = buf_q;
            buf_full_d     = 1'b0;
            frame_period_d = (bit_period_q < 14'd2) ? 14'd2 : bit_period_q;
            frame_size_d   = data_size_q;
            cnt_d          = 14'd1;
            serial_d       = 1'b0;
        end

        if (access && !pwrite && paddr == 3'd1) begin
            overrun_d = 1'b0;
        end

        if (access && pwrite && !pslverr) begin
            case (paddr)
                3'd2: bit_period_d[7:0]  = pwdata;
                3'd3: bit_period_d[13:8] = pwdata[5:0];
                3'd4: data_size_d        = pwdata[3:0];
                3'd6: begin
                    if (!buf_full_q || load_frame) begin
                        buf_d      = pwdata;
                        tx_data_d  = pwdata;
                        buf_full_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= S_IDLE;
            bit_period_q   <= RESET_BIT_PERIOD;
            data_size_q    <= RESET_DATA_SIZE;
            tx_data_q      <= 8'h00;
            buf_q          <= 8'h00;
            buf_full_q     <= 1'b0;
            overrun_q      <= 1'b0;
            shift_q        <= 8'h00;
            cnt_q          <= 14'd1;
            bit_idx_q      <= 4'd0;
            frame_period_q <= 14'd2;
            frame_size_q   <= 4'd8;
            serial_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            bit_period_q   <= bit_period_d;
            data_size_q    <= data_size_d;
            tx_data_q      <= tx_data_d;
            buf_q          <= buf_d;
            buf_full_q     <= buf_full_d;
            overrun_q      <= overrun_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            frame_period_q <= frame_period_d;
            frame_size_q   <= frame_size_d;
            serial_q       <= serial_d;
        end
    end

endmodule

// File: doc/apb_uart_tx.md
# apb_uart_tx

APB-slave-controlled UART transmitter: the transmit-side counterpart of the team's APB UART receiver, sharing its register map style, bit-period and data-size configuration. Software writes a byte over APB into a one-entry holding buffer; the block frames and shifts it out on `serial_out` LSB-first with one start and one stop bit. It sits on the same APB segment as the receiver, and its `serial_out` drives the external UART line.

## Interface
- `RESET_BIT_PERIOD`, 14'd10, bit period in clocks after reset
- `RESET_DATA_SIZE`, 4'd8, data bits per frame after reset
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `psel`  in  1  APB select
- `paddr`  in  3  APB address
- `penable`  in  1  APB access phase
- `pwrite`  in  1  1 = write, 0 = read
- `pwdata`  in  8  APB write data
- `prdata`  out  8  APB read data, combinational, valid while `psel`
- `pslverr`  out  1  APB error, combinational, meaningful when `psel & penable`
- `serial_out`  out  1  UART line, registered, idles high

## Operation
- Register map:
  - 0 status (RO): bit0 `busy` (FSM not IDLE), bit1 `buf_full`, others 0.
  - 1 error (RO): bit0 `overrun`, sticky; cleared by a read access of addr 1.
  - 2 bit period [7:0] (RW).
  - 3 bit period [13:8] (RW); bits [7:6] write-ignored and read 0.
  - 4 data size (RW): only 5..8 are accepted.
  - 6 TX data (RW): a write loads the holding buffer; a read returns the last value written.
- Every register update is gated by `psel & penable` and committed on that edge.
- `pslverr` = 1 for:
  - writes to addr 0 or 1;
  - any access to addr 5 or 7;
  - a data-size write outside 5..8. That register is left unchanged.
- A rejected write changes no state.
- Write to addr 6 while `buf_full` = 1:
  - the data is dropped and `overrun` is set;
  - `pslverr` = 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when `buf_full`. On that edge: buffer moves to the shift register, `buf_full` clears, and bit period and data size are latched for the frame.
  - START -> DATA after one bit period.
  - DATA -> STOP after `data_size` bit periods. Bits go out LSB first; buffer bits above `data_size` are ignored.
  - STOP -> START directly if `buf_full` (back-to-back, no idle gap); otherwise STOP -> IDLE, after one bit period.
- Bit timer: counts 1..period and advances the bit when it reaches period. An effective period of 0 or 1 is treated as 2.
- Config writes during a frame take effect only at the next frame start.

## Timing
- Reset values (first edge with `rst` = 1):
  - `serial_out` = 1, FSM IDLE;
  - `buf_full` = 0, `overrun` = 0;
  - bit period = `RESET_BIT_PERIOD`, data size = `RESET_DATA_SIZE`;
  - `prdata` = 0 whenever `psel` = 0.
- Reset mid-frame aborts the frame: `serial_out` is 1 from the next edge and the buffer is discarded.
- Write to addr 6 on access edge E:
  - `buf_full` = 1 after E;
  - if IDLE, FSM -> START at E+1 and `serial_out` = 0 from E+1.
- Frame length = (data_size + 2) × period clocks; each bit is held exactly `period` clocks.
- Status reads reflect register state as of the previous edge; APB is zero-wait-state (no `pready`).
- Overrun set and error-register read in the same access cycle: the set wins, and the read returns the pre-edge value.
- A TX data write on the same edge the FSM empties the buffer is accepted without overrun.

## Test plan
- Reset, then read addrs 0/1/2/3/4 -> 0x00 / 0x00 / 0x0A / 0x00 / 0x08; `serial_out` = 1.
- Config and transmit:
  - Stimulus: period 10, size 8, write 0xA5 to addr 6.
  - `serial_out` 0 for 10 clocks starting at E+1, then bits 1,0,1,0,0,1,0,1 at 10 clocks each, then 1 for 10 clocks.
  - Status busy = 1 throughout; 0 after 100 clocks.
- Size 5, write 0xFF -> 5 data bits of 1, frame = 70 clocks; a size-3 write gets `pslverr` = 1 and addr 4 still reads 5.
- Back-to-back:
  - Stimulus: write 0x01, then 0x02 while sending.
  - Second start bit begins on the clock right after the first stop bit ends.
  - A third write while `buf_full` -> addr 1 reads 0x01, then 0x00 on the next read.
- Error cases: write addr 0 -> `pslverr` = 1; read/write addr 7 -> `pslverr` = 1; read addr 6 -> last written byte with `pslverr` = 0.
- Assert `rst` mid-DATA -> `serial_out` = 1 next edge, status 0x00, and a new write transmits a correct full frame.
